// File: rtl/fifo_burst_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_reader_pkg
// Description : Shared constants and width helpers for the FIFO burst reader.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_burst_reader_pkg;

    // Upper bound on the depth of the attached FIFO.
    localparam int unsigned FBR_MAX_DEPTH = 2 ** 16;

    // Bits needed to hold every value in 0..max_val (never less than one).
    function automatic int unsigned bits_for(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage : fifo_burst_reader_pkg
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_reader
// Description : Pops a non-fall-through FIFO in bursts of up to BURST_LEN onto
//               a registered valid/ready stream; a timeout flushes partials.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned TIMEOUT    = 16,
    parameter type         dtype      = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  fifo_full_i,
    input  logic                  fifo_empty_i,
    input  logic [ADDR_DEPTH-1:0] fifo_usage_i,
    input  dtype                  fifo_data_i,
    output logic                  fifo_pop_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output dtype                  out_data_o,
    output logic                  out_last_o,
    output logic                  busy_o
);

    localparam int unsigned c_OCC_W   = ADDR_DEPTH + 1;
    localparam int unsigned c_BEATS_W = bits_for(BURST_LEN);
    localparam int unsigned c_TIMER_W = bits_for(TIMEOUT);

    localparam logic [c_OCC_W-1:0]   c_DEPTH_OCC   = c_OCC_W'(DEPTH);
    localparam logic [c_OCC_W-1:0]   c_BURST_OCC   = c_OCC_W'(BURST_LEN);
    localparam logic [c_BEATS_W-1:0] c_BURST_BEATS = c_BEATS_W'(BURST_LEN);
    localparam logic [c_BEATS_W-1:0] c_ONE_BEAT    = c_BEATS_W'(1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_MAX   = c_TIMER_W'(TIMEOUT);
    localparam logic [c_TIMER_W-1:0] c_TIMER_ONE   = c_TIMER_W'(1);
    localparam bit                   c_TIMEOUT_EN  = (TIMEOUT != 0);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e               r_state;
    logic [c_TIMER_W-1:0] r_timer;
    logic [c_BEATS_W-1:0] r_beats;
    logic                 r_out_valid;
    logic                 r_out_last;
    dtype                 r_out_data;

    logic [c_OCC_W-1:0]   w_occ;
    logic                 w_occ_nz;
    logic                 w_full_burst;
    logic                 w_timeout_hit;
    logic                 w_start;
    logic [c_BEATS_W-1:0] w_start_beats;
    logic                 w_pop;

    // usage_o wraps to zero on a full FIFO, so full has to override it.
    assign w_occ         = fifo_full_i ? c_DEPTH_OCC : {1'b0, fifo_usage_i};
    assign w_occ_nz      = (w_occ != '0);
    assign w_full_burst  = (w_occ >= c_BURST_OCC);
    assign w_timeout_hit = c_TIMEOUT_EN && (r_timer == c_TIMER_MAX) && w_occ_nz;
    assign w_start       = (r_state == IDLE) && (w_full_burst || w_timeout_hit);
    assign w_start_beats = w_full_burst ? c_BURST_BEATS : c_BEATS_W'(w_occ);

    assign w_pop = (r_state == BURST) && !flush_i && !fifo_empty_i &&
                   (r_beats != '0) && (!r_out_valid || out_ready_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_beats     <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else if (flush_i) begin
            // An unaccepted beat is discarded; payload register keeps its value.
            r_state     <= IDLE;
            r_timer     <= '0;
            r_beats     <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_out_data  <= fifo_data_i;
                r_out_valid <= 1'b1;
                r_out_last  <= (r_beats == c_ONE_BEAT);
            end else if (r_out_valid && out_ready_i) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= BURST;
                        r_beats <= w_start_beats;
                        r_timer <= '0;
                    end else if (!w_occ_nz) begin
                        r_timer <= '0;
                    end else if (!w_full_burst && (r_timer != c_TIMER_MAX)) begin
                        r_timer <= r_timer + c_TIMER_ONE;
                    end
                end
                BURST: begin
                    if (w_pop) begin
                        r_beats <= r_beats - c_ONE_BEAT;
                        if (r_beats == c_ONE_BEAT) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign fifo_pop_o  = w_pop;
    assign out_valid_o = r_out_valid;
    assign out_last_o  = r_out_last;
    assign out_data_o  = r_out_data;
    assign busy_o      = (r_state == BURST);

`ifndef SYNTHESIS
    a_burst_len_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (BURST_LEN >= 1) && (BURST_LEN <= DEPTH) && (DEPTH <= FBR_MAX_DEPTH));

    a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
        fifo_pop_o |-> !fifo_empty_i);

    a_out_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_o && !out_ready_i && !flush_i) |=>
        (out_valid_o && $stable(out_data_o) && $stable(out_last_o)));
`endif

endmodule : fifo_burst_reader
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_burst_reader
// Description : Scoreboard bench for fifo_burst_reader with a FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_reader;

    localparam int unsigned DW    = 32;
    localparam int          DEPTH = 8;
    localparam int unsigned AD    = 3;
    localparam int unsigned CW    = AD + 1;

    typedef logic [DW-1:0] word_t;
    typedef struct packed {
        word_t d;
        logic  l;
    } exp_t;

    logic    clk = 1'b0;
    logic    rst_n;
    logic    flush;
    logic    flush2;
    logic    out_ready;
    logic    fifo_full;
    logic    fifo_empty;
    logic [AD-1:0] fifo_usage;
    word_t   fifo_data;
    logic    fifo_pop;
    logic    out_valid;
    logic    out_last;
    logic    busy;
    word_t   out_data;
    logic    pop2;
    logic    out_valid2;
    logic    out_last2;
    logic    busy2;
    word_t   out_data2;

    word_t         mem [DEPTH];
    logic [AD-1:0] rd_ptr;
    logic [AD-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          pl_req;
    logic          fifo_clear;
    int            pl_n;
    word_t         pl_base;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int busy_total = 0;
    int wait_total = 0;
    int pop_total = 0;
    int pop2_total = 0;
    int busy2_total = 0;
    logic  prev_stall = 1'b0;
    logic  prev_flush = 1'b0;
    logic  prev_last = 1'b0;
    word_t prev_data = '0;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .BURST_LEN  (4),
        .TIMEOUT    (16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .fifo_full_i  (fifo_full),
        .fifo_empty_i (fifo_empty),
        .fifo_usage_i (fifo_usage),
        .fifo_data_i  (fifo_data),
        .fifo_pop_o   (fifo_pop),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_last_o   (out_last),
        .busy_o       (busy)
    );

    // Observer instance: watches the same FIFO, its pops do not drain it.
    fifo_burst_reader #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .BURST_LEN  (4),
        .TIMEOUT    (0)
    ) dut_nto (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush2),
        .fifo_full_i  (fifo_full),
        .fifo_empty_i (fifo_empty),
        .fifo_usage_i (fifo_usage),
        .fifo_data_i  (fifo_data),
        .fifo_pop_o   (pop2),
        .out_valid_o  (out_valid2),
        .out_ready_i  (1'b1),
        .out_data_o   (out_data2),
        .out_last_o   (out_last2),
        .busy_o       (busy2)
    );

    assign fifo_full  = count[AD];
    assign fifo_empty = (count == '0);
    assign fifo_usage = count[AD-1:0];
    assign fifo_data  = mem[rd_ptr];

    always @(posedge clk) begin
        if (fifo_clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pl_req) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (i < pl_n) mem[wr_ptr + AD'(i)] <= pl_base + word_t'(i);
                end
            end
            wr_ptr <= wr_ptr + (pl_req ? AD'(pl_n) : '0);
            rd_ptr <= rd_ptr + AD'(fifo_pop);
            count  <= count + (pl_req ? CW'(pl_n) : '0) - CW'(fifo_pop);
        end
    end

    task automatic chk(input string name, input word_t act, input word_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Writes n entries in one edge; entry i carries last flag mask[i].
    task automatic preload(input int n, input word_t base, input logic [7:0] mask, input bit sb);
        for (int i = 0; i < n; i++) begin
            if (sb) exp_q.push_back('{d: base + word_t'(i), l: mask[i]});
        end
        pl_req  = 1'b1;
        pl_n    = n;
        pl_base = base;
        @(posedge clk); #1;
        pl_req  = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, word_t'(exp_q.size()), '0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none", out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_data", out_data, mon_e.d);
                    chk("beat_last", word_t'(out_last), word_t'(mon_e.l));
                end
            end
            if (fifo_pop) begin
                pop_total++;
                chk("pop_legal", word_t'(fifo_empty || (out_valid && !out_ready)), '0);
            end
            if (prev_stall && !prev_flush) begin
                chk("stall_valid", word_t'(out_valid), 1);
                chk("stall_data", out_data, prev_data);
                chk("stall_last", word_t'(out_last), word_t'(prev_last));
            end
            if (busy) busy_total++;
            if (count != '0 && !busy) wait_total++;
            if (pop2) pop2_total++;
            if (busy2) busy2_total++;
            prev_stall = out_valid && !out_ready;
            prev_flush = flush;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int b0;
        int p0;
        int w0;
        int p2;
        int b2;
        rst_n      = 1'b0;
        flush      = 1'b0;
        flush2     = 1'b1;
        out_ready  = 1'b1;
        pl_req     = 1'b0;
        pl_n       = 0;
        pl_base    = '0;
        fifo_clear = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", word_t'(out_valid), 0);
        chk("rst_last", word_t'(out_last), 0);
        chk("rst_data", out_data, 0);
        chk("rst_pop", word_t'(fifo_pop), 0);
        chk("rst_busy", word_t'(busy), 0);
        @(posedge clk); #1;
        rst_n      = 1'b1;
        fifo_clear = 1'b0;
        @(posedge clk); #1;

        // Full burst of 4
        b0 = busy_total; p0 = pop_total;
        preload(4, 32'hA000_0000, 8'h08, 1'b1);
        wait_drain(40, "t1_drain");
        chk("t1_busy", word_t'(busy_total - b0), 4);
        chk("t1_pops", word_t'(pop_total - p0), 4);

        // Partial fill forced out by the timeout
        b0 = busy_total; w0 = wait_total;
        preload(3, 32'hB000_0000, 8'h04, 1'b1);
        wait_drain(60, "t2_drain");
        chk("t2_wait", word_t'(wait_total - w0), 17);
        chk("t2_busy", word_t'(busy_total - b0), 3);

        // Full FIFO: usage wraps to 0
        b0 = busy_total;
        preload(8, 32'hC000_0000, 8'h88, 1'b1);
        wait_drain(60, "t3_drain");
        chk("t3_busy", word_t'(busy_total - b0), 8);

        // Backpressure toggling
        p0 = pop_total;
        preload(4, 32'hD000_0000, 8'h08, 1'b1);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            out_ready = i[0];
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_drain(20, "t4_drain");
        chk("t4_pops", word_t'(pop_total - p0), 4);

        // Flush while beat 2 is presented
        p0 = pop_total;
        preload(4, 32'hE000_0000, 8'h08, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("t5_valid", word_t'(out_valid), 0);
        chk("t5_last", word_t'(out_last), 0);
        chk("t5_busy", word_t'(busy), 0);
        chk("t5_count", word_t'(count), 2);
        chk("t5_pops_at_flush", word_t'(pop_total - p0), 2);
        @(posedge clk); #1;
        wait_drain(60, "t5_drain");
        chk("t5_pops", word_t'(pop_total - p0), 4);

        // Timeout disabled: single entry never starts a burst
        flush      = 1'b1;
        fifo_clear = 1'b1;
        @(posedge clk); #1;
        fifo_clear = 1'b0;
        flush2     = 1'b0;
        p2 = pop2_total; b2 = busy2_total;
        preload(1, 32'h6000_0000, 8'h00, 1'b0);
        repeat (100) begin @(posedge clk); #1; end
        chk("t6_no_pop", word_t'(pop2_total - p2), 0);
        chk("t6_no_busy", word_t'(busy2_total - b2), 0);
        preload(3, 32'h6000_0001, 8'h00, 1'b0);
        @(negedge clk);
        chk("t6_idle_at_fill", word_t'(busy2), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_busy", word_t'(busy2), 1);
        chk("t6_pop", word_t'(pop2), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_valid", word_t'(out_valid2), 1);
        chk("t6_data", out_data2, 32'h6000_0000);
        @(posedge clk); #1;
        flush2     = 1'b1;
        fifo_clear = 1'b1;
        @(posedge clk); #1;
        fifo_clear = 1'b0;
        flush      = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fifo_burst_reader
`default_nettype wire
